// File: rtl/ieu32_pkg.sv
// Shared types and constants for the IEU32 RV32I instruction encoder.
// Holds inst_type one-hot bit positions, opcodes, the NOP word and the S1 request record.
package ieu32_pkg;

  localparam int IDX_R = 5;
  localparam int IDX_I = 4;
  localparam int IDX_S = 3;
  localparam int IDX_B = 2;
  localparam int IDX_U = 1;
  localparam int IDX_J = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef struct packed {
    logic [5:0]  inst_type;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [9:0]  fun;
    logic [31:0] imm;
    logic        err;
  } req_t;

  // True when v is representable as a signed value of the given bit count.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/ieu32_if.sv
// Request/response bundle of the IEU32 encoder; slave = encoder side, master = producer/consumer side.
interface ieu32_if #(
  parameter int INST_MAX = 32,
  parameter int WIDTH    = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [5:0]          inst_type;
  logic [6:0]          opcode;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [9:0]          fun;
  logic [WIDTH-1:0]    imm;
  logic                out_valid;
  logic                out_ready;
  logic [INST_MAX-1:0] inst;
  logic                err;
  logic [15:0]         enc_cnt;

  modport slave (
    input  in_valid, inst_type, opcode, rd, rs1, rs2, fun, imm, out_ready,
    output in_ready, out_valid, inst, err, enc_cnt
  );

  modport master (
    output in_valid, inst_type, opcode, rd, rs1, rs2, fun, imm, out_ready,
    input  in_ready, out_valid, inst, err, enc_cnt
  );
endinterface

// File: rtl/ieu32_packer.sv
// Combinational RV32I field assembly from a registered S1 request; flagged requests become NOP.
module ieu32_packer
  import ieu32_pkg::*;
(
  input  req_t        req,
  output logic [31:0] word
);

  logic [2:0] f3;
  logic [6:0] f7;

  assign f3 = req.fun[9:7];
  assign f7 = req.fun[6:0];

  always_comb begin
    word = NOP_WORD;
    if (!req.err) begin
      if (req.inst_type[IDX_R])
        word = {f7, req.rs2, req.rs1, f3, req.rd, req.opcode};
      else if (req.inst_type[IDX_I])
        word = {req.imm[11:0], req.rs1, f3, req.rd, req.opcode};
      else if (req.inst_type[IDX_S])
        word = {req.imm[11:5], req.rs2, req.rs1, f3, req.imm[4:0], req.opcode};
      else if (req.inst_type[IDX_B])
        word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, f3,
                req.imm[4:1], req.imm[11], req.opcode};
      else if (req.inst_type[IDX_U])
        word = {req.imm[31:12], req.rd, req.opcode};
      else if (req.inst_type[IDX_J])
        word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                req.rd, req.opcode};
    end
  end

endmodule

// File: rtl/ieu32.sv
// IEU32: two-stage RV32I instruction encoder with valid/ready on both sides.
// Define IEU32_RANGE_CHECK_EN to reject immediates that do not fit their format.
module ieu32
  import ieu32_pkg::*;
#(
  parameter int INST_MAX = 32,
  parameter int WIDTH    = 32
) (
  input  logic    clk,
  input  logic    rst,
  ieu32_if.slave  bus
);

  logic [31:0] imm_ext;
  logic        type_err;
  logic        range_err;
  req_t        req_next;

  logic        s1_valid_reg;
  req_t        s1_req_reg;
  logic        s2_valid_reg;
  logic [31:0] inst_reg;
  logic        err_reg;
  logic [15:0] enc_cnt_reg;

  logic        s1_ready;
  logic        s2_ready;
  logic [31:0] packed_word;

  generate
    if (WIDTH >= 32) begin : g_imm_trunc
      assign imm_ext = bus.imm[31:0];
    end else begin : g_imm_sext
      assign imm_ext = {{(32-WIDTH){bus.imm[WIDTH-1]}}, bus.imm};
    end
  endgenerate

  assign type_err = !$onehot(bus.inst_type);

`ifdef IEU32_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    if (bus.inst_type[IDX_I] || bus.inst_type[IDX_S])
      range_err = !fits_signed(imm_ext, 12);
    if (bus.inst_type[IDX_B])
      range_err = !fits_signed(imm_ext, 13) || imm_ext[0];
    if (bus.inst_type[IDX_J])
      range_err = !fits_signed(imm_ext, 21) || imm_ext[0];
    if (bus.inst_type[IDX_U])
      range_err = (imm_ext[11:0] != 12'h000);
  end
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    req_next.inst_type = bus.inst_type;
    req_next.opcode    = bus.opcode;
    req_next.rd        = bus.rd;
    req_next.rs1       = bus.rs1;
    req_next.rs2       = bus.rs2;
    req_next.fun       = bus.fun;
    req_next.imm       = imm_ext;
    req_next.err       = type_err || range_err;
  end

  // A stage may load when empty or when its contents move on this cycle.
  assign s2_ready = !s2_valid_reg || bus.out_ready;
  assign s1_ready = !s1_valid_reg || s2_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_req_reg   <= '0;
    end else if (s1_ready) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid)
        s1_req_reg <= req_next;
    end
  end

  ieu32_packer u_packer (
    .req  (s1_req_reg),
    .word (packed_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      inst_reg     <= '0;
      err_reg      <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        inst_reg <= packed_word;
        err_reg  <= s1_req_reg.err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      enc_cnt_reg <= '0;
    else if (s2_valid_reg && bus.out_ready && enc_cnt_reg != 16'hFFFF)
      enc_cnt_reg <= enc_cnt_reg + 16'd1;
  end

  // The stages are already empty under reset; the gate keeps producers out until release.
  assign bus.in_ready  = !rst && s1_ready;
  assign bus.out_valid = s2_valid_reg;
  assign bus.err       = err_reg;
  assign bus.enc_cnt   = enc_cnt_reg;

  generate
    if (INST_MAX > 32) begin : g_inst_wide
      assign bus.inst = {{(INST_MAX-32){1'b0}}, inst_reg};
    end else begin : g_inst_fit
      assign bus.inst = inst_reg[INST_MAX-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_ieu32.sv
// Scoreboard bench for ieu32: directed requests push expected words, a monitor pops on each output handshake.
module tb_ieu32;
  import ieu32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ieu32_if #(.INST_MAX(32), .WIDTH(32)) bus ();

  ieu32 #(.INST_MAX(32), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          exp_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got inst 0x%08h, required no output", bus.inst);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".inst"}, bus.inst, mon_e.inst);
        check({mon_e.name, ".err"}, {31'd0, bus.err}, {31'd0, mon_e.err});
        if (mon_e.exp_cyc >= 0)
          check({mon_e.name, ".latency"}, cyc, mon_e.exp_cyc);
      end
    end
  end

  task automatic send(input string name, input logic [5:0] t, input logic [6:0] op,
                      input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                      input logic [9:0] fun_v, input logic [31:0] imm_v,
                      input logic [31:0] exp_inst, input logic exp_err, input bit chk_lat);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst_type = t;
    bus.opcode    = op;
    bus.rd        = rd_v;
    bus.rs1       = rs1_v;
    bus.rs2       = rs2_v;
    bus.fun       = fun_v;
    bus.imm       = imm_v;
    for (int w = 0; w < 100 && !ok; w++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout %s: got in_ready=0 for 100 cycles, required acceptance", name);
    end else begin
      e.inst    = exp_inst;
      e.err     = exp_err;
      e.exp_cyc = chk_lat ? cyc + 2 : -1;
      e.name    = name;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout %s: got %0d words outstanding, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] T_R = 6'b100000;
  localparam logic [5:0] T_I = 6'b010000;
  localparam logic [5:0] T_S = 6'b001000;
  localparam logic [5:0] T_B = 6'b000100;
  localparam logic [5:0] T_U = 6'b000010;
  localparam logic [5:0] T_J = 6'b000001;

`ifdef IEU32_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  initial begin
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.inst_type = T_R;
    bus.opcode    = OP_REG;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.fun       = '0;
    bus.imm       = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.err",       {31'd0, bus.err},       32'd0);
    check("rst.inst",      bus.inst,               32'd0);
    check("rst.enc_cnt",   {16'd0, bus.enc_cnt},   32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    send("r_add",  T_R, OP_REG,    5'd3, 5'd1, 5'd2, 10'h000, 32'h0,        32'h002081B3, 1'b0, 1'b1);
    send("i_neg1", T_I, OP_IMM,    5'd1, 5'd0, 5'd0, 10'h000, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b0);
    send("b_8",    T_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 10'h000, 32'h8,        32'h00208463, 1'b0, 1'b0);
    send("b_9",    T_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 10'h000, 32'h9,
         RC ? NOP_WORD : 32'h00208463, RC, 1'b0);
    send("i_800",  T_I, OP_IMM,    5'd0, 5'd0, 5'd0, 10'h000, 32'h800,
         RC ? NOP_WORD : 32'h80000013, RC, 1'b0);
    send("bad_type", 6'b000011, OP_LUI, 5'd5, 5'd0, 5'd0, 10'h000, 32'h0, NOP_WORD, 1'b1, 1'b0);
    send("r_sub",  T_R, OP_REG,    5'd3, 5'd1, 5'd2, 10'h020, 32'h0,        32'h402081B3, 1'b0, 1'b0);
    send("s_sw",   T_S, OP_STORE,  5'd0, 5'd2, 5'd5, 10'h100, 32'hFFFFFFFC, 32'hFE512E23, 1'b0, 1'b0);
    send("u_lui",  T_U, OP_LUI,    5'd5, 5'd0, 5'd0, 10'h000, 32'h12345000, 32'h123452B7, 1'b0, 1'b0);
    send("u_low",  T_U, OP_LUI,    5'd5, 5'd0, 5'd0, 10'h000, 32'h12345678,
         RC ? NOP_WORD : 32'h123452B7, RC, 1'b0);
    send("j_800",  T_J, OP_JAL,    5'd1, 5'd0, 5'd0, 10'h000, 32'h800,      32'h001000EF, 1'b0, 1'b0);
    send("j_m2",   T_J, OP_JAL,    5'd0, 5'd0, 5'd0, 10'h000, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0, 1'b0);
    wait_drain("directed");
    check("directed.enc_cnt", {16'd0, bus.enc_cnt}, 32'd12);

    // Backpressure: four offered, only two fit while the consumer stalls.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send("bp0", T_R, OP_REG, 5'd4, 5'd1, 5'd2, 10'h000, 32'h0, 32'h00208233, 1'b0, 1'b0);
        send("bp1", T_I, OP_IMM, 5'd1, 5'd0, 5'd0, 10'h000, 32'h5, 32'h00500093, 1'b0, 1'b0);
        send("bp2", T_U, OP_LUI, 5'd5, 5'd0, 5'd0, 10'h000, 32'h12345000, 32'h123452B7, 1'b0, 1'b0);
        send("bp3", T_R, OP_REG, 5'd3, 5'd1, 5'd2, 10'h020, 32'h0, 32'h402081B3, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp.accepted", n_acc, 32'd2);
        check("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp.out_valid_held", {31'd0, bus.out_valid}, 32'd1);
        check("bp.inst_held", bus.inst, 32'h00208233);
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("bp");
    check("bp.enc_cnt", {16'd0, bus.enc_cnt}, 32'd4);

    // Reset with both stages occupied must drop everything at once.
    bus.out_ready = 1'b0;
    send("rs0", T_R, OP_REG, 5'd3, 5'd1, 5'd2, 10'h000, 32'h0, 32'h002081B3, 1'b0, 1'b0);
    send("rs1", T_R, OP_REG, 5'd3, 5'd1, 5'd2, 10'h020, 32'h0, 32'h402081B3, 1'b0, 1'b0);
    check("rs.pre_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("rs.pre_in_ready",  {31'd0, bus.in_ready},  32'd0);
    rst = 1'b1;
    #1;
    check("rs.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rs.enc_cnt",   {16'd0, bus.enc_cnt},   32'd0);
    check("rs.in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rs.inst",      bus.inst,               32'd0);
    sb.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("rs.release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("rs.no_stale_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rs.final_enc_cnt",  {16'd0, bus.enc_cnt},   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
